// File: rtl/sr_latch_seq_pkg.sv
// Shared types and constants for the gated SR latch sequencer.
// Optional readback checking is enabled by defining SR_LATCH_SEQ_VERIFY_EN.
package sr_latch_seq_pkg;

  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_GATE  = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Round-robin pointer advance; wraps at the requester count, not at 2**IDX_W.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur, input int n);
    if (int'(cur) >= n - 1) return '0;
    return cur + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sr_latch_seq_rr_arb.sv
// Combinational round-robin arbiter: lowest requesting index at or above ptr wins,
// wrapping to 0. The pointer itself is owned by the sequencer.
module rr_arb
  import sr_latch_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!grant_vld && req[pos]) begin
        grant_vld  = 1'b1;
        grant_idx  = IDX_W'(pos);
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_seq.sv
// Arbitrating sequencer that is the sole driver of a shared gated NAND SR latch.
// Define SR_LATCH_SEQ_VERIFY_EN to add the CHECK state and the sticky err readback flag.
module sr_latch_seq
  import sr_latch_seq_pkg::*;
#(
  parameter int N        = 4,
  parameter int GATE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] op,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         s,
  output logic         r,
  output logic         c,
  input  logic         q_in,
  input  logic         nq_in,
  output logic         err,
  output logic         last_q
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     sel;
  logic             cur_op;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0]     arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic             op_sel;
  logic             op_nxt;
  logic             drive_sr;

  rr_arb #(.N(N)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign op_sel = |(op & arb_grant);
  assign op_nxt = (state == ST_IDLE) ? op_sel : cur_op;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arb_vld) state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_GATE;
      ST_GATE:  if (cnt == '0) state_nxt = ST_HOLD;
`ifdef SR_LATCH_SEQ_VERIFY_EN
      ST_HOLD:  state_nxt = ST_CHECK;
`else
      ST_HOLD:  state_nxt = ST_DONE;
`endif
      ST_CHECK: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // s/r stay asserted from SETUP until the gate has been closed for a full cycle.
  assign drive_sr = (state_nxt == ST_SETUP) || (state_nxt == ST_GATE) ||
                    (state_nxt == ST_HOLD)  || (state_nxt == ST_CHECK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      idx    <= '0;
      sel    <= '0;
      cur_op <= OP_CLR;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && arb_vld) begin
        idx    <= arb_idx;
        sel    <= arb_grant;
        cur_op <= op_sel;
      end
      if (state == ST_SETUP) begin
        cnt <= CNT_W'(GATE_CYC - 1);
      end else if (state == ST_GATE && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == ST_DONE) begin
        ptr <= next_ptr(idx, N);
      end
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      busy   <= 1'b0;
      s      <= 1'b0;
      r      <= 1'b0;
      c      <= 1'b0;
      last_q <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      s    <= drive_sr & op_nxt;
      r    <= drive_sr & ~op_nxt;
      c    <= (state_nxt == ST_GATE);
      gnt  <= (state_nxt == ST_DONE) ? sel : '0;
      if (state_nxt == ST_DONE) begin
        last_q <= cur_op;
      end
    end
  end

`ifdef SR_LATCH_SEQ_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == ST_CHECK && (q_in != cur_op || nq_in == q_in)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = q_in ^ nq_in;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_seq.sv
// Scoreboard bench for sr_latch_seq driving a behavioural gated NAND SR latch.
// Expected latency follows whether SR_LATCH_SEQ_VERIFY_EN is defined for the build.
`timescale 1ns/1ps
module tb_sr_latch_seq;

  localparam int N  = 4;
  localparam int GC = 2;
`ifdef SR_LATCH_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LAT    = VERIFY ? GC + 4 : GC + 3;
  localparam int PERIOD = LAT + 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] op;
  logic [N-1:0] gnt;
  logic         busy, s, r, c;
  logic         q_in, nq_in;
  logic         err, last_q;

  logic latch_q = 1'b0;
  logic fault_q0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic         lq;
    int           at;
  } exp_t;

  exp_t sb[$];

  sr_latch_seq #(.N(N), .GATE_CYC(GC)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .gnt    (gnt),
    .busy   (busy),
    .s      (s),
    .r      (r),
    .c      (c),
    .q_in   (q_in),
    .nq_in  (nq_in),
    .err    (err),
    .last_q (last_q)
  );

  // Gated latch: transparent while c is high, holds otherwise; s=r=1 leaves it untouched.
  always @(s or r or c) begin
    if (c && s && !r) latch_q = 1'b1;
    else if (c && r && !s) latch_q = 1'b0;
  end
  assign q_in  = fault_q0 ? 1'b0 : latch_q;
  assign nq_in = ~latch_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
    vectors++;
    if ((c && !(s ^ r)) || (s && r)) begin
      miscompares++;
      $display("[TB] FAIL invariant cyc=%0d: s=%b r=%b c=%b, required c->s^r and never s&r", cyc, s, r, c);
    end
  endtask

  function automatic void expect_gnt(input logic [N-1:0] g, input logic lq, input int at);
    exp_t e;
    e.gnt = g;
    e.lq  = lq;
    e.at  = at;
    sb.push_back(e);
  endfunction

  task automatic serve(input int n, input bit drop, input int budget);
    int   seen;
    int   spent;
    exp_t e;
    seen  = 0;
    spent = 0;
    while (seen < n && spent < budget) begin
      tick();
      spent++;
      if (gnt != '0) begin
        seen++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_gnt cyc=%0d: gnt=%b, required no grant", cyc, gnt);
        end else begin
          e = sb.pop_front();
          if (gnt !== e.gnt || last_q !== e.lq || cyc != e.at) begin
            miscompares++;
            $display("[TB] FAIL gnt_seq: got gnt=%b last_q=%b cyc=%0d, required gnt=%b last_q=%b cyc=%0d",
                     gnt, last_q, cyc, e.gnt, e.lq, e.at);
          end
        end
        if (drop) req = req & ~gnt;
      end
    end
    if (seen < n) begin
      miscompares++;
      $display("[TB] FAIL serve_timeout: saw %0d grants, required %0d", seen, n);
    end
    req = '0;
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1; req = '0; op = '0; fault_q0 = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({gnt, busy, s, r, c, err, last_q} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_vals: gnt=%b busy=%b s=%b r=%b c=%b err=%b last_q=%b, required all 0",
               gnt, busy, s, r, c, err, last_q);
    end
    rst = 1'b0;
    tick();
    req = 4'b0001; op = 4'b0001; k = cyc;
    expect_gnt(4'b0001, 1'b1, k + LAT);
    tick();
    vectors++;
    if ({busy, s, r, c} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL setup_cycle: busy,s,r,c=%b, required 1100", {busy, s, r, c});
    end
    for (int i = 0; i < GC; i++) begin
      tick();
      vectors++;
      if ({s, r, c} !== 3'b101) begin
        miscompares++;
        $display("[TB] FAIL gate_cycle%0d: s,r,c=%b, required 101", i, {s, r, c});
      end
    end
    tick();
    vectors++;
    if ({busy, s, r, c} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL hold_cycle: busy,s,r,c=%b, required 1100", {busy, s, r, c});
    end
    serve(1, 1'b1, 20);
    vectors++;
    if (err !== 1'b0 || latch_q !== 1'b1 || {s, r, c} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL first_op: err=%b latch=%b srC=%b, required err=0 latch=1 src=000", err, latch_q, {s, r, c});
    end
  endtask

  task automatic test_contention();
    int k;
    repeat (2) tick();
    req = 4'b1010; op = 4'b0010; k = cyc;
    expect_gnt(4'b0010, 1'b1, k + LAT);
    expect_gnt(4'b1000, 1'b0, k + LAT + PERIOD);
    serve(2, 1'b1, 40);
    vectors++;
    if (last_q !== 1'b0 || latch_q !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL contention_final: last_q=%b latch=%b, required 0 0", last_q, latch_q);
    end
  endtask

  task automatic test_fairness();
    int                 k;
    logic [N-1:0]       onehot;
    logic [N-1:0]       opv;
    opv = 4'b0101;
    repeat (2) tick();
    req = 4'b1111; op = opv; k = cyc;
    for (int i = 0; i < 5; i++) begin
      onehot = '0;
      onehot[i % N] = 1'b1;
      expect_gnt(onehot, opv[i % N], k + LAT + i * PERIOD);
    end
    serve(5, 1'b0, 80);
  endtask

  task automatic test_readback_fault();
    int k;
    repeat (2) tick();
    fault_q0 = 1'b1;
    req = 4'b0010; op = 4'b0010; k = cyc;
    expect_gnt(4'b0010, 1'b1, k + LAT);
    repeat (LAT - 1) tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_early: err=%b, required 0 before the operation completes", err);
    end
    serve(1, 1'b1, 10);
    vectors++;
    if (err !== VERIFY) begin
      miscompares++;
      $display("[TB] FAIL err_set: err=%b, required %b", err, VERIFY);
    end
    fault_q0 = 1'b0;
    tick();
    req = 4'b0100; op = 4'b0000; k = cyc;
    expect_gnt(4'b0100, 1'b0, k + LAT);
    serve(1, 1'b1, 20);
    vectors++;
    if (err !== VERIFY || latch_q !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: err=%b latch=%b, required err=%b latch=0", err, latch_q, VERIFY);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_clear: err=%b, required 0 after rst", err);
    end
  endtask

  task automatic test_midop_reset();
    int k;
    int spent;
    repeat (2) tick();
    req = 4'b0001; op = 4'b0001;
    spent = 0;
    while (c !== 1'b1 && spent < 10) begin
      tick();
      spent++;
    end
    vectors++;
    if (c !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gate_timeout: c=%b, required 1 within 10 cycles", c);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({s, r, c, busy, gnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: s=%b r=%b c=%b busy=%b gnt=%b, required all 0", s, r, c, busy, gnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({gnt, busy} !== '0) begin
        miscompares++;
        $display("[TB] FAIL aborted_gnt: gnt=%b busy=%b, required 0 0", gnt, busy);
      end
    end
    rst = 1'b0; k = cyc;
    expect_gnt(4'b0001, 1'b1, k + LAT);
    serve(1, 1'b1, 20);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fairness();
    test_readback_fault();
    test_midop_reset();
    repeat (3) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sr_latch_seq.md
# sr_latch_seq

Sequencer and arbiter for one shared gated NAND SR latch. N requesters post set or clear operations. The block grants them round-robin and drives the latch's set/reset/gate inputs in a safe sequence. With verification compiled in, it reads back the latch outputs and reports each operation's completion with a one-cycle acknowledge. It is the only driver of the latch's s, r and c inputs, and the gate is never opened with both s and r high.

## Interface
Parameters:
- N, 4: number of requesters (2..8).
- GATE_CYC, 2: cycles the gate input c is held high per operation (1..15).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request level; held until that requester's gnt bit pulses.
- op  input  N  per-requester operation; 1 = set (q→1), 0 = clear (q→0); held with req.
- gnt  output  N  one-hot acknowledge, one-cycle pulse when the operation completes.
- busy  output  1  high from SETUP through DONE.
- s  output  1  latch set input.
- r  output  1  latch reset input.
- c  output  1  latch gate input.
- q_in  input  1  latch q output.
- nq_in  input  1  latch nq output.
- err  output  1  sticky readback mismatch flag (see Configuration).
- last_q  output  1  value written by the most recent completed operation.

## Operation
- Outputs are registered and are functions of state only (Moore).
- States and transitions:
  - IDLE: if any req bit is set, the round-robin arbiter picks one index, starting the search at ptr. Index and op are captured, then go to SETUP.
  - SETUP: one cycle; s = op, r = ~op, c = 0; then GATE.
  - GATE: GATE_CYC cycles; c = 1 with s/r held; a 4-bit down counter times it; then HOLD.
  - HOLD: one cycle; c = 0, s/r still held; then CHECK (verify build) or DONE.
  - CHECK: one cycle; if q_in != op or nq_in == q_in, set err; then DONE.
  - DONE: one cycle; gnt[idx] = 1, last_q = op, ptr = (idx+1) mod N, s = r = 0; then IDLE.
- In IDLE: s = r = c = 0.
- Invariant: whenever c = 1, exactly one of s and r is 1. When c = 0, s = r = 1 never occurs.
- A request deasserted before its gnt is still completed, because it was already captured. A new req arriving mid-operation waits for IDLE.
- Simultaneous requests: the lowest index at or above ptr wins, wrapping to 0.
- err is sticky: cleared only by rst.

## Timing
- Accept edge is T, when IDLE sees req. gnt pulses in cycle T+GATE_CYC+4 with verify, or T+GATE_CYC+3 without.
- Back-to-back: the next accept happens in the cycle after DONE. Throughput is one operation per GATE_CYC+5 cycles with verify.
- Reset values: gnt = 0, busy = 0, s = r = c = 0, err = 0, last_q = 0, ptr = 0, state = IDLE.
- Reset mid-operation forces all outputs to 0 immediately, without waiting for clk. The latch keeps whatever value it held, and no gnt is issued for the aborted operation.
- q_in and nq_in are sampled only in CHECK, a full cycle after c falls, so no synchroniser is needed.

## Configuration
- SR_LATCH_SEQ_VERIFY_EN defined: the CHECK state exists and err is live.
- Undefined:
  - HOLD goes directly to DONE.
  - err is tied to 0.
  - q_in and nq_in are unused.
  - Latency is reduced by one cycle.

## Structure
- Package sr_latch_seq_pkg holds:
  - the state encoding typedef (IDLE, SETUP, GATE, HOLD, CHECK, DONE);
  - OP_SET = 1 and OP_CLR = 0;
  - the counter width constant.
- One sub-module, rr_arb: N-input round-robin arbiter.
  - Inputs: req and ptr.
  - Outputs: a one-hot grant and its index.
  - Purely combinational; the pointer register lives in the sequencer.

## Test plan
Bench: N=4, GATE_CYC=2, SR_LATCH_SEQ_VERIFY_EN defined, driving the team's NAND gated SR latch model.
- Reset: hold rst for 3 cycles, then assert req=4'b0001, op=4'b0001 → SETUP in T+1, c high in T+2..T+3, gnt=4'b0001 in T+6, last_q=1, err=0.
- Contention: req=4'b1010 held, op=4'b0010 → gnt[1] first, then gnt[3] (clear), each exactly 7 cycles apart; final last_q=0.
- Fairness: req=4'b1111 held continuously → gnt order 0,1,2,3,0; an assertion on every cycle that c=1 implies s^r=1.
- Readback fault: force q_in=0 during a set operation → err=1 in the cycle after CHECK, and it stays 1 through later good operations until rst.
- Mid-operation reset: assert rst asynchronously during GATE → s, r, c, busy and gnt go to 0 before the next clk edge; the re-issued request completes normally.
- Macro off: rebuild without SR_LATCH_SEQ_VERIFY_EN → gnt in T+5, and err stays 0 under the forced q_in fault.
